// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if: bundles the I-cache, D-cache and physical-memory line ports
// of the arbiter. The slave modport is the arbiter's view; the master modport is
// the view of the surrounding caches and memory that drive it.
interface pmem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LINE_W = 128
);
    // I-cache side
    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_address;
    logic              i_pmem_resp;
    logic [LINE_W-1:0] i_pmem_rdata;
    // D-cache side
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic              d_pmem_resp;
    logic [LINE_W-1:0] d_pmem_rdata;
    // Physical memory side
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [LINE_W-1:0] pmem_rdata;

    modport slave (
        input  i_pmem_read, i_pmem_address,
        output i_pmem_resp, i_pmem_rdata,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output d_pmem_resp, d_pmem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

    modport master (
        output i_pmem_read, i_pmem_address,
        input  i_pmem_resp, i_pmem_rdata,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  d_pmem_resp, d_pmem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata
    );
endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory line port between the LC-3b I-cache
// and D-cache. One requester is granted at a time; its address, write data and
// direction are latched for the whole transaction and the response is routed
// back only to the granted side. Default arbitration is D-first with an
// I-starvation guard; defining PMEM_ARB_RR_EN switches ties to round-robin.
module pmem_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned LINE_W       = 128,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           rst_n,
    pmem_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_BUSY = 2'd1;
    localparam logic [1:0] D_BUSY = 2'd2;
    localparam logic [1:0] GAP    = 2'd3;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("pmem_arbiter: STARVE_LIMIT must be within 1..15");
    end

    logic [1:0]        state_q, state_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              d_req, i_req, d_wins;
    logic              grant_d, grant_i;

`ifdef PMEM_ARB_RR_EN
    // High when I was granted last, so D takes the next tie
    logic last_i_q, last_i_d;
`else
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    logic [3:0] starve_q, starve_d;
`endif

    // Arbitration between pending requests while IDLE
    always_comb begin
        d_req = bus.d_pmem_read | bus.d_pmem_write;
        i_req = bus.i_pmem_read;
`ifdef PMEM_ARB_RR_EN
        d_wins = !i_req || last_i_q;
`else
        d_wins = !i_req || (starve_q < STARVE_MAX);
`endif
        grant_d = (state_q == IDLE) && d_req && d_wins;
        grant_i = (state_q == IDLE) && i_req && !grant_d;
    end

    // Next-state, latched transaction fields and registered strobes
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = D_BUSY;
                    addr_d  = bus.d_pmem_address;
                    wdata_d = bus.d_pmem_wdata;
                    // Write wins when both read and write are raised
                    wr_d    = bus.d_pmem_write;
                    rd_d    = !bus.d_pmem_write;
                end else if (grant_i) begin
                    state_d = I_BUSY;
                    addr_d  = bus.i_pmem_address;
                    rd_d    = 1'b1;
                    wr_d    = 1'b0;
                end
            end
            I_BUSY, D_BUSY: begin
                if (bus.pmem_resp) begin
                    state_d = GAP;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PMEM_ARB_RR_EN
    // Remember which side won the most recent grant
    always_comb begin
        last_i_d = last_i_q;
        if (grant_i) begin
            last_i_d = 1'b1;
        end else if (grant_d) begin
            last_i_d = 1'b0;
        end
    end

    // Last-grant flop, reset to I so D wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_i_q <= 1'b1;
        end else begin
            last_i_q <= last_i_d;
        end
    end
`else
    // Count D grants taken while I waits; cleared by any I grant or uncontended D grant
    always_comb begin
        starve_d = starve_q;
        if (grant_i) begin
            starve_d = 4'd0;
        end else if (grant_d) begin
            starve_d = i_req ? starve_q + 4'd1 : 4'd0;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // Main state and transaction registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Memory outputs and response routing; resp is only forwarded while busy
    always_comb begin
        bus.pmem_read    = rd_q;
        bus.pmem_write   = wr_q;
        bus.pmem_address = addr_q;
        bus.pmem_wdata   = wdata_q;
        bus.i_pmem_resp  = (state_q == I_BUSY) && bus.pmem_resp;
        bus.d_pmem_resp  = (state_q == D_BUSY) && bus.pmem_resp;
        bus.i_pmem_rdata = bus.pmem_rdata;
        bus.d_pmem_rdata = bus.pmem_rdata;
    end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single physical-memory line port between the instruction cache and the data cache of the LC-3b core.
- Each cache presents the same pmem_* handshake it would drive to memory directly.
- The arbiter grants one requester at a time and latches that requester's address, write data and direction for the whole transaction.
- It routes the memory response back only to the granted cache, using fixed data-first priority with an instruction-starvation guard.

Parameters:
- ADDR_W, 16, width of line address (lc3b_word)
- LINE_W, 128, width of cache line (lc3b_line)
- STARVE_LIMIT, 4, consecutive D grants allowed while I is pending before I is forced; range 1..15

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- i_pmem_read  input  1  I-cache line fill request
- i_pmem_address  input  ADDR_W  I-cache line address
- i_pmem_resp  output  1  I-cache transaction done
- i_pmem_rdata  output  LINE_W  line data to I-cache
- d_pmem_read  input  1  D-cache line fill request
- d_pmem_write  input  1  D-cache write-back request
- d_pmem_address  input  ADDR_W  D-cache line address
- d_pmem_wdata  input  LINE_W  D-cache write-back line
- d_pmem_resp  output  1  D-cache transaction done
- d_pmem_rdata  output  LINE_W  line data to D-cache
- pmem_read  output  1  memory read strobe
- pmem_write  output  1  memory write strobe
- pmem_address  output  ADDR_W  latched transaction address
- pmem_wdata  output  LINE_W  latched write-back line
- pmem_resp  input  1  memory transaction done
- pmem_rdata  input  LINE_W  memory read line

Behaviour:
Reset (rst_n low, asynchronous):
- state=IDLE; pmem_read, pmem_write = 0; pmem_address, pmem_wdata = 0.
- starve_cnt=0; last-grant = I.
- Applies immediately even mid-transaction; any in-flight memory access is abandoned.
- No resp is forwarded while in reset.

States: IDLE, I_BUSY, D_BUSY, GAP.

IDLE — evaluated each cycle:
- d_req = d_pmem_read | d_pmem_write; i_req = i_pmem_read.
- Only d_req: go to D_BUSY.
- Only i_req: go to I_BUSY.
- Both, and starve_cnt < STARVE_LIMIT: go to D_BUSY, starve_cnt+1.
- Both, and starve_cnt == STARVE_LIMIT: go to I_BUSY.
- Any I grant clears starve_cnt; a D grant with no I pending clears starve_cnt.
- On the grant edge, latch the granted address into pmem_address and d_pmem_wdata into pmem_wdata (D only).
- Also latch dir = write if d_pmem_write, else read. If d_pmem_read and d_pmem_write are both high, write wins.

I_BUSY / D_BUSY:
- pmem_read / pmem_write held per the latched dir from the cycle after grant until the resp cycle inclusive (registered outputs).
- Grant-to-strobe latency is one cycle.
- Changes on requester address/data during BUSY are ignored.
- When pmem_resp=1: the granted side's *_pmem_resp = 1 combinationally in that same cycle; the other side's resp stays 0.
- In that same cycle, next state = GAP and the strobes are cleared at the edge.

GAP:
- Exactly one cycle; all requests ignored so a requester can drop its request after resp.
- Then return to IDLE.

Data and response routing:
- i_pmem_rdata and d_pmem_rdata are always driven by pmem_rdata (unbuffered); the resp gates validity.
- pmem_resp in IDLE or GAP is ignored and not forwarded.
- Requester deasserting mid-BUSY does not abort; the transaction completes and the resp pulse is still issued.

Throughput: back-to-back transactions are spaced by at least 2 cycles (GAP + IDLE arbitration).

Optional Feature:
Macro PMEM_ARB_RR_EN.
- Defined: when both requests are pending in IDLE, grant the side not granted last (round-robin via a last-grant flop, reset to I, so D wins the first tie). starve_cnt and STARVE_LIMIT are unused and optimised away.
- Undefined: fixed D priority with the starvation guard described above.
- All other timing is identical in both builds.

Test Plan:
- I-only read at 0x1230; memory resp on the 3rd BUSY cycle with rdata=0xA5…A5. Required: pmem_read high 1 cycle after request; pmem_address=0x1230; i_pmem_resp single pulse with the data; d_pmem_resp=0; then GAP, IDLE.
- D write-back to 0x4560 with wdata=0x0123…CDEF, and d_pmem_address changed to 0x7770 mid-BUSY. Required: pmem_write=1; pmem_address stays 0x4560; pmem_wdata unchanged; d_pmem_resp pulses once.
- I and D held continuously with STARVE_LIMIT=4, fixed-priority build. Required grant order: D,D,D,D,I,D,D,D,D,I; starve_cnt cleared after each I grant.
- Same stimulus built with PMEM_ARB_RR_EN. Required grant order: D,I,D,I…
- pmem_resp asserted while IDLE. Required: no i_/d_pmem_resp; state unchanged.
- rst_n dropped mid D_BUSY. Required: pmem_read/write drop immediately (asynchronously); after release, state=IDLE and a pending I request is granted in the next arbitration cycle.
